// File: rtl/prog_seq_counter_if.sv
// Control, table-write and status signals of the programmable-sequence counter.
// The master side drives control and table writes; the slave side returns the count and status.
interface prog_seq_counter_if #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 8
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LEN_W = PTR_W + 1;

  logic             en;
  logic             dir;
  logic             mode;
  logic             restart;
  logic [LEN_W-1:0] len;
  logic             wr_en;
  logic [PTR_W-1:0] wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] count;
  logic [PTR_W-1:0] ptr;
  logic             wrap;
  logic             done;

  modport master (
    output en, dir, mode, restart, len, wr_en, wr_addr, wr_data,
    input  count, ptr, wrap, done
  );

  modport slave (
    input  en, dir, mode, restart, len, wr_en, wr_addr, wr_data,
    output count, ptr, wrap, done
  );
endinterface

// File: rtl/prog_seq_counter.sv
// Programmable-sequence counter: steps a pointer through a writable flop table and
// outputs the addressed code, with wrap/one-shot modes, direction and run-time length.
module prog_seq_counter #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 8
) (
  input logic              clk,
  input logic              clear,
  prog_seq_counter_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LEN_W = PTR_W + 1;

  logic [WIDTH-1:0] tbl [DEPTH];
  logic [PTR_W-1:0] last;
  logic [PTR_W-1:0] start;
  logic [PTR_W-1:0] nxt;
  logic             wrap_nxt;
  logic             done_nxt;
  logic [WIDTH-1:0] code_nxt;

  function automatic logic [WIDTH-1:0] init_code(input int i);
    return WIDTH'(5 * i + 3);
  endfunction

  always_comb begin
    if (bus.len == '0 || bus.len > LEN_W'(DEPTH))
      last = PTR_W'(DEPTH - 1);
    else
      last = PTR_W'(bus.len - LEN_W'(1));
    start = bus.dir ? last : '0;
  end

  always_comb begin
    nxt      = bus.ptr;
    wrap_nxt = 1'b0;
    done_nxt = bus.done;
    if (bus.restart) begin
      nxt      = start;
      done_nxt = 1'b0;
    end else if (bus.en && !bus.done) begin
      // A shortened len can strand ptr beyond the new end; treat that as a wrap to start.
      if (bus.ptr > last) begin
        nxt      = start;
        wrap_nxt = !bus.mode;
      end else if ((!bus.dir && bus.ptr == last) || (bus.dir && bus.ptr == '0)) begin
        if (bus.mode) begin
          done_nxt = 1'b1;
        end else begin
          nxt      = bus.dir ? last : '0;
          wrap_nxt = 1'b1;
        end
      end else begin
        nxt = bus.dir ? bus.ptr - PTR_W'(1) : bus.ptr + PTR_W'(1);
      end
    end
  end

  // Forward a same-edge write to the entry being landed on so count is never stale.
  always_comb begin
    if (bus.wr_en && bus.wr_addr == nxt)
      code_nxt = bus.wr_data;
    else
      code_nxt = tbl[nxt];
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++)
        tbl[i] <= init_code(i);
      bus.ptr   <= start;
      bus.count <= init_code(int'(start));
      bus.wrap  <= 1'b0;
      bus.done  <= 1'b0;
    end else begin
      if (bus.wr_en)
        tbl[bus.wr_addr] <= bus.wr_data;
      bus.ptr   <= nxt;
      bus.count <= code_nxt;
      bus.wrap  <= wrap_nxt;
      bus.done  <= done_nxt;
    end
  end
endmodule

// File: tb/tb_prog_seq_counter.sv
// Directed bench for prog_seq_counter: reset, both directions, one-shot, write-through,
// enable gating, run-time length change and asynchronous clear.
module tb_prog_seq_counter;
  logic clk = 1'b0;
  logic clear;
  int   checks = 0;
  int   errors = 0;

  prog_seq_counter_if #(.WIDTH(3), .DEPTH(8)) bus ();

  prog_seq_counter #(.WIDTH(3), .DEPTH(8)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reset table contents: (5*i+3) mod 8
  logic [2:0] codes [8] = '{3'd3, 3'd0, 3'd5, 3'd2, 3'd7, 3'd4, 3'd1, 3'd6};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear       = 1'b1;
    bus.en      = 1'b0;
    bus.dir     = 1'b0;
    bus.mode    = 1'b0;
    bus.restart = 1'b0;
    bus.len     = 4'd0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = 3'd0;
    bus.wr_data = 3'd0;
    #12;
    checks++;
    if (bus.count !== 3'd3) begin errors++; $display("FAIL reset_count got %0d want 3", bus.count); end
    checks++;
    if (bus.ptr !== 3'd0) begin errors++; $display("FAIL reset_ptr got %0d want 0", bus.ptr); end
    checks++;
    if (bus.wrap !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL reset_flags got wrap=%b done=%b want 0 0", bus.wrap, bus.done);
    end
    tick();
    clear = 1'b0;
  endtask

  task automatic test_wrap_fwd();
    logic [2:0] exp [8] = '{3'd0, 3'd5, 3'd2, 3'd7, 3'd4, 3'd1, 3'd6, 3'd3};
    logic w;
    bus.en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      w = (i == 7);
      checks++;
      if (bus.count !== exp[i]) begin errors++; $display("FAIL fwd_count step %0d got %0d want %0d", i, bus.count, exp[i]); end
      checks++;
      if (bus.wrap !== w) begin errors++; $display("FAIL fwd_wrap step %0d got %b want %b", i, bus.wrap, w); end
    end
    bus.en = 1'b0;
    tick();
    checks++;
    if (bus.wrap !== 1'b0) begin errors++; $display("FAIL fwd_wrap_pulse got %b want 0", bus.wrap); end
  endtask

  task automatic test_backward();
    logic [2:0] p;
    bus.dir = 1'b1;
    bus.restart = 1'b1;
    tick();
    bus.restart = 1'b0;
    checks++;
    if (bus.ptr !== 3'd7 || bus.count !== 3'd6) begin
      errors++; $display("FAIL back_start got ptr=%0d count=%0d want ptr=7 count=6", bus.ptr, bus.count);
    end
    bus.en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      p = 3'(6 - i);
      tick();
      checks++;
      if (bus.ptr !== p || bus.count !== codes[p]) begin
        errors++; $display("FAIL back_step %0d got ptr=%0d count=%0d want ptr=%0d count=%0d", i, bus.ptr, bus.count, p, codes[p]);
      end
      checks++;
      if (bus.wrap !== (i == 7)) begin errors++; $display("FAIL back_wrap step %0d got %b want %b", i, bus.wrap, (i == 7)); end
    end
    bus.en = 1'b0;
    bus.dir = 1'b0;
  endtask

  task automatic test_one_shot();
    logic [2:0] exp [3] = '{3'd0, 3'd5, 3'd2};
    bus.mode = 1'b1;
    bus.len = 4'd4;
    bus.restart = 1'b1;
    tick();
    bus.restart = 1'b0;
    checks++;
    if (bus.count !== 3'd3 || bus.done !== 1'b0) begin
      errors++; $display("FAIL oneshot_start got count=%0d done=%b want 3 0", bus.count, bus.done);
    end
    bus.en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.count !== exp[i] || bus.done !== 1'b0) begin
        errors++; $display("FAIL oneshot_step %0d got count=%0d done=%b want %0d 0", i, bus.count, bus.done, exp[i]);
      end
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (bus.count !== 3'd2 || bus.ptr !== 3'd3 || bus.done !== 1'b1 || bus.wrap !== 1'b0) begin
        errors++; $display("FAIL oneshot_hold %0d got count=%0d ptr=%0d done=%b wrap=%b want 2 3 1 0", i, bus.count, bus.ptr, bus.done, bus.wrap);
      end
    end
    bus.en = 1'b0;
    bus.restart = 1'b1;
    tick();
    bus.restart = 1'b0;
    checks++;
    if (bus.count !== 3'd3 || bus.done !== 1'b0) begin
      errors++; $display("FAIL oneshot_restart got count=%0d done=%b want 3 0", bus.count, bus.done);
    end
    bus.mode = 1'b0;
    bus.len = 4'd0;
  endtask

  task automatic test_write_through();
    logic [2:0] exp [8] = '{3'd5, 3'd2, 3'd7, 3'd0, 3'd1, 3'd6, 3'd3, 3'd7};
    bus.wr_en = 1'b1;
    bus.wr_addr = 3'd1;
    bus.wr_data = 3'd7;
    bus.en = 1'b1;
    tick();
    checks++;
    if (bus.count !== 3'd7 || bus.ptr !== 3'd1) begin
      errors++; $display("FAIL wt_forward got count=%0d ptr=%0d want 7 1", bus.count, bus.ptr);
    end
    bus.en = 1'b0;
    bus.wr_addr = 3'd5;
    bus.wr_data = 3'd0;
    tick();
    bus.wr_en = 1'b0;
    checks++;
    if (bus.count !== 3'd7) begin errors++; $display("FAIL wt_other_index got count=%0d want 7", bus.count); end
    bus.en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (bus.count !== exp[i]) begin errors++; $display("FAIL wt_revisit step %0d got %0d want %0d", i, bus.count, exp[i]); end
    end
    bus.en = 1'b0;
  endtask

  task automatic test_en_gate();
    logic       pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [2:0] exp [4] = '{3'd5, 3'd5, 3'd5, 3'd2};
    for (int i = 0; i < 4; i++) begin
      bus.en = pat[i];
      tick();
      checks++;
      if (bus.count !== exp[i] || bus.wrap !== 1'b0) begin
        errors++; $display("FAIL en_gate %0d got count=%0d wrap=%b want %0d 0", i, bus.count, bus.wrap, exp[i]);
      end
    end
    bus.en = 1'b0;
  endtask

  task automatic test_len_change();
    bus.en = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (bus.ptr !== 3'd6 || bus.count !== 3'd1) begin
      errors++; $display("FAIL len_pre got ptr=%0d count=%0d want 6 1", bus.ptr, bus.count);
    end
    bus.len = 4'd4;
    tick();
    checks++;
    if (bus.ptr !== 3'd0 || bus.count !== 3'd3 || bus.wrap !== 1'b1) begin
      errors++; $display("FAIL len_jump got ptr=%0d count=%0d wrap=%b want 0 3 1", bus.ptr, bus.count, bus.wrap);
    end
    tick(); tick(); tick(); tick();
    checks++;
    if (bus.ptr !== 3'd0 || bus.wrap !== 1'b1) begin
      errors++; $display("FAIL len4_wrap got ptr=%0d wrap=%b want 0 1", bus.ptr, bus.wrap);
    end
    bus.dir = 1'b1;
    tick();
    checks++;
    if (bus.ptr !== 3'd3 || bus.count !== 3'd2 || bus.wrap !== 1'b1) begin
      errors++; $display("FAIL len4_back got ptr=%0d count=%0d wrap=%b want 3 2 1", bus.ptr, bus.count, bus.wrap);
    end
    bus.dir = 1'b0;
    tick();
    checks++;
    if (bus.ptr !== 3'd0 || bus.wrap !== 1'b1) begin
      errors++; $display("FAIL dir_flip got ptr=%0d wrap=%b want 0 1", bus.ptr, bus.wrap);
    end
    bus.len = 4'd0;
    tick();
    bus.en = 1'b0;
    checks++;
    if (bus.ptr !== 3'd1 || bus.count !== 3'd7 || bus.wrap !== 1'b0) begin
      errors++; $display("FAIL len_restore got ptr=%0d count=%0d wrap=%b want 1 7 0", bus.ptr, bus.count, bus.wrap);
    end
  endtask

  task automatic test_clear();
    bus.en = 1'b1;
    tick();
    #3;
    clear = 1'b1;
    #1;
    checks++;
    if (bus.count !== 3'd3 || bus.ptr !== 3'd0 || bus.done !== 1'b0 || bus.wrap !== 1'b0) begin
      errors++; $display("FAIL clear_async got count=%0d ptr=%0d done=%b wrap=%b want 3 0 0 0", bus.count, bus.ptr, bus.done, bus.wrap);
    end
    tick();
    clear = 1'b0;
    tick();
    checks++;
    if (bus.ptr !== 3'd1 || bus.count !== 3'd0) begin
      errors++; $display("FAIL clear_restore1 got ptr=%0d count=%0d want 1 0", bus.ptr, bus.count);
    end
    tick(); tick(); tick(); tick();
    checks++;
    if (bus.ptr !== 3'd5 || bus.count !== 3'd4) begin
      errors++; $display("FAIL clear_restore5 got ptr=%0d count=%0d want 5 4", bus.ptr, bus.count);
    end
    bus.en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_wrap_fwd();
    test_backward();
    test_one_shot();
    test_write_through();
    test_en_gate();
    test_len_change();
    test_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
